// File: rtl/mvm_pkg.sv
// Widths and helpers shared across the MVM engine stages.
package mvm_pkg;

  localparam int IWIDTH_DEF     = 32;
  localparam int OWIDTH_DEF     = 32;
  localparam int CTRL_DELAY_DEF = 3;
  localparam int FIFO_DEPTH_DEF = 16;

  // Count width is one bit wider than the pointers so that "full" can be represented.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FIFO_CNT_W = fifo_cnt_w(FIFO_DEPTH_DEF);

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_e;

endpackage

// File: rtl/result_fifo.sv
// Circular result FIFO with valid/ready drain and sticky drop flag.
//   state        | meaning
//   FILL_EMPTY   | count == 0, head invalid, o_data forced to 0
//   FILL_PARTIAL | 0 < count < DEPTH
//   FILL_FULL    | count == DEPTH, push accepted only alongside a pop
module result_fifo
  import mvm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_ready,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_valid,
  output logic [fifo_cnt_w(DEPTH)-1:0] o_count,
  output logic                         o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  fill_e w_fill;
  logic  w_pop;
  logic  w_push_ok;

  always_comb begin
    w_fill = FILL_PARTIAL;
    if (r_count == '0)
      w_fill = FILL_EMPTY;
    else if (r_count == CW'(DEPTH))
      w_fill = FILL_FULL;
  end

  assign w_pop     = (w_fill != FILL_EMPTY) & i_ready;
  assign w_push_ok = i_push & ((w_fill != FILL_FULL) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push_ok)
        r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wptr] <= i_data;
  end

  assign o_valid    = (w_fill != FILL_EMPTY);
  assign o_data     = o_valid ? r_mem[r_rptr] : '0;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/accum_lane.sv
// Per-lane row accumulator: aligns the control stream to the datapath, sums partials, queues row results.
module accum_lane
  import mvm_pkg::*;
#(
  parameter int IWIDTH     = IWIDTH_DEF,
  parameter int OWIDTH     = OWIDTH_DEF,
  parameter int CTRL_DELAY = CTRL_DELAY_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ivalid,
  input  logic                     accum_first,
  input  logic                     accum_last,
  input  logic signed [IWIDTH-1:0] idata,
  output logic signed [OWIDTH-1:0] odata,
  output logic                     ovalid,
  input  logic                     oready,
  output logic                     busy,
  output logic                     overflow
);

  logic [CTRL_DELAY-1:0]    r_dv;
  logic [CTRL_DELAY-1:0]    r_df;
  logic [CTRL_DELAY-1:0]    r_dl;
  logic signed [OWIDTH-1:0] r_acc;

  logic                             w_dv;
  logic                             w_df;
  logic                             w_dl;
  logic signed [OWIDTH-1:0]         w_ext;
  logic signed [OWIDTH-1:0]         w_acc_next;
  logic [fifo_cnt_w(FIFO_DEPTH)-1:0] w_count;

  assign w_dv = r_dv[CTRL_DELAY-1];
  assign w_df = r_df[CTRL_DELAY-1];
  assign w_dl = r_dl[CTRL_DELAY-1];

  assign w_ext      = OWIDTH'(idata);
  assign w_acc_next = w_df ? w_ext : r_acc + w_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv  <= '0;
      r_df  <= '0;
      r_dl  <= '0;
      r_acc <= '0;
    end else begin
      r_dv[0] <= ivalid;
      r_df[0] <= accum_first;
      r_dl[0] <= accum_last;
      for (int i = 1; i < CTRL_DELAY; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_df[i] <= r_df[i-1];
        r_dl[i] <= r_dl[i-1];
      end
      // A continuation word without a preceding first simply builds on the stale sum.
      if (w_dv)
        r_acc <= w_acc_next;
    end
  end

  result_fifo #(
    .WIDTH (OWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_dv & w_dl),
    .i_data     (w_acc_next),
    .i_ready    (oready),
    .o_data     (odata),
    .o_valid    (ovalid),
    .o_count    (w_count),
    .o_overflow (overflow)
  );

  assign busy = (|r_dv) | (w_count != '0);

endmodule
